// File: rtl/iter_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define ITER_DIVIDER_SIGNED_EN to compile in two's-complement (signed) support.
module iter_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic             load;
    logic             dvd_neg, dvs_neg;
    logic             qsign_q, rsign_q;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] quot_fin, rem_fin;

    assign load = (state_q == S_IDLE) && start;

`ifdef ITER_DIVIDER_SIGNED_EN
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
        end else if (load) begin
            qsign_q <= dvd_neg ^ dvs_neg;
            rsign_q <= dvd_neg;
        end
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign dvd_neg = 1'b0;
    assign dvs_neg = 1'b0;
    assign qsign_q = 1'b0;
    assign rsign_q = 1'b0;
`endif

    // Trial subtraction is two bits wider than the divisor so the borrow is the sign.
    assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    assign diff     = rem_sh - {2'b00, dvs_q};
    assign quot_fin = qsign_q ? -dvd_q : dvd_q;
    assign rem_fin  = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    dz_d    = (divisor == '0);
                    dvd_d   = (dvd_neg && divisor != '0) ? -dividend : dividend;
                    dvs_d   = dvs_neg ? -divisor : divisor;
                end
            end
            S_RUN: begin
                // Divide-by-zero spends one cycle here so DONE lands one edge after load.
                if (dz_q) begin
                    state_d = S_DONE;
                    quot_d  = '1;
                    remo_d  = dvd_q;
                    dbz_d   = 1'b1;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d = S_DONE;
                    quot_d  = quot_fin;
                    remo_d  = rem_fin;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!diff[WIDTH+1]) begin
                        rem_d = diff[WIDTH:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: stimulus pushes expectations, a monitor checks each done.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    iter_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: runs 1 time unit after each rising edge, compares whenever done is up.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_quot"}, quotient, mon_e.q);
                chk({mon_e.name, "_rem"}, remainder, mon_e.r);
                chk({mon_e.name, "_dbz"}, 32'(div_by_zero), 32'(mon_e.dz));
                chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
        end
    end

    task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int glitch);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        e.name = name;
        e.q    = eq;
        e.r    = er;
        e.dz   = edz;
        e.lat  = (b == 32'd0) ? 1 : 33;
        e.t0   = cyc;
        sb.push_back(e);
        chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0BAD_F00D;
        for (int k = 1; k <= 100 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (k == glitch) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done within 100 cycles want done", name);
            sb.delete();
        end
        @(posedge clk);
        #2;
        chk({name, "_busy_idle"}, 32'(busy), 32'd0);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_quot_hold"}, quotient, eq);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
        do_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 0);
        do_div("div0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        do_div("sdiv0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0);
        do_div("uffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        do_div("uffff_ffff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
        do_div("u0_5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 0);
        do_div("u5_10", 1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 0);
`ifdef ITER_DIVIDER_SIGNED_EN
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);
        do_div("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 0);
`else
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 0);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0, 0);
        do_div("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FF9C, 1'b0, 0);
`endif
        do_div("ignored_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);

        // Abort an operation with reset at cycle 20; no done may follow.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quot", quotient, 32'd0);
        chk("abort_rem", remainder, 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #2;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        do_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
